// File: rtl/logip_pkg.sv
// rtl/logip_pkg.sv - shared types, opcodes and config struct for the logIP SUMP command controller.
package logip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_EXEC    = 2'd2
    } state_t;

    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_ARM       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_XON       = 8'h11;
    localparam logic [7:0] OP_XOFF      = 8'h13;
    localparam logic [7:0] OP_TRIG_MASK = 8'hC0;
    localparam logic [7:0] OP_TRIG_VAL  = 8'hC1;
    localparam logic [7:0] OP_TRIG_CFG  = 8'hC2;
    localparam logic [7:0] OP_DIV       = 8'h80;
    localparam logic [7:0] OP_CNT       = 8'h81;
    localparam logic [7:0] OP_FLAGS     = 8'h82;

    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic [31:0] trig_mask;
        logic [31:0] trig_val;
        logic [31:0] trig_cfg;
        logic [23:0] divider;
        logic [15:0] read_cnt;
        logic [15:0] delay_cnt;
        logic [7:0]  flags;
    } sump_cfg_t;

    // Opcodes that target a config register; only these can be dropped while busy.
    function automatic logic is_cfg_op(input logic [7:0] op);
        return (op == OP_TRIG_MASK) || (op == OP_TRIG_VAL) || (op == OP_TRIG_CFG) ||
               (op == OP_DIV) || (op == OP_CNT) || (op == OP_FLAGS);
    endfunction

endpackage

// File: rtl/sump_cmd_ctrl.sv
// rtl/sump_cmd_ctrl.sv - SUMP byte-stream parser, command pulses and capture config registers.
// Optional payload inactivity timeout built when LOGIP_CMD_TIMEOUT_EN is defined.
module sump_cmd_ctrl
    import logip_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        capture_busy_i,
    output logic        cmd_reset_o,
    output logic        cmd_arm_o,
    output logic        id_req_o,
    output logic        cfg_drop_o,
    output logic [31:0] trig_mask_o,
    output logic [31:0] trig_val_o,
    output logic [31:0] trig_cfg_o,
    output logic [23:0] divider_o,
    output logic [15:0] read_cnt_o,
    output logic [15:0] delay_cnt_o,
    output logic [7:0]  flags_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                 state;
    logic [7:0]             opcode;
    logic [PAYLOAD_W-1:0]   payload;
    logic [1:0]             byte_cnt;
    sump_cfg_t              cfg;
    logic                   accept_cmd;

`ifdef LOGIP_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;
`endif

    // EXEC behaves like IDLE for an incoming byte, so no byte is ever lost.
    assign accept_cmd = rx_valid_i && ((state == ST_IDLE) || (state == ST_EXEC));

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state       <= ST_IDLE;
            opcode      <= '0;
            payload     <= '0;
            byte_cnt    <= '0;
            cfg         <= '0;
            cmd_reset_o <= 1'b0;
            cmd_arm_o   <= 1'b0;
            id_req_o    <= 1'b0;
            cfg_drop_o  <= 1'b0;
`ifdef LOGIP_CMD_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            cmd_reset_o <= 1'b0;
            cmd_arm_o   <= 1'b0;
            id_req_o    <= 1'b0;
            cfg_drop_o  <= 1'b0;

            case (state)
                ST_IDLE: ;
                ST_PAYLOAD: begin
                    if (rx_valid_i) begin
                        payload[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_EXEC;
                        end
`ifdef LOGIP_CMD_TIMEOUT_EN
                        to_cnt <= '0;
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    if (capture_busy_i) begin
                        cfg_drop_o <= is_cfg_op(opcode);
                    end else begin
                        case (opcode)
                            OP_TRIG_MASK: cfg.trig_mask <= payload;
                            OP_TRIG_VAL:  cfg.trig_val  <= payload;
                            OP_TRIG_CFG:  cfg.trig_cfg  <= payload;
                            OP_DIV:       cfg.divider   <= payload[23:0];
                            OP_CNT: begin
                                cfg.read_cnt  <= payload[15:0];
                                cfg.delay_cnt <= payload[31:16];
                            end
                            OP_FLAGS:     cfg.flags     <= payload[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the state case so a new command started in EXEC overrides its return to IDLE.
            if (accept_cmd) begin
                if (rx_data_i[7]) begin
                    opcode   <= rx_data_i;
                    payload  <= '0;
                    byte_cnt <= '0;
                    state    <= ST_PAYLOAD;
`ifdef LOGIP_CMD_TIMEOUT_EN
                    to_cnt   <= '0;
`endif
                end else begin
                    case (rx_data_i)
                        OP_RESET:         cmd_reset_o <= 1'b1;
                        OP_ARM:           cmd_arm_o   <= !capture_busy_i;
                        OP_ID:            id_req_o    <= 1'b1;
                        OP_XON, OP_XOFF:  ;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign trig_mask_o = cfg.trig_mask;
    assign trig_val_o  = cfg.trig_val;
    assign trig_cfg_o  = cfg.trig_cfg;
    assign divider_o   = cfg.divider;
    assign read_cnt_o  = cfg.read_cnt;
    assign delay_cnt_o = cfg.delay_cnt;
    assign flags_o     = cfg.flags;

endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// tb/tb_sump_cmd_ctrl.sv - self-checking bench for sump_cmd_ctrl against a command-level model.
module tb_sump_cmd_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        busy = 1'b0;
    logic        cmd_reset, cmd_arm, id_req, cfg_drop;
    logic [31:0] trig_mask, trig_val, trig_cfg;
    logic [23:0] divider;
    logic [15:0] read_cnt, delay_cnt;
    logic [7:0]  flags;

    sump_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i          (clk),
        .rst_in         (rst_n),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .capture_busy_i (busy),
        .cmd_reset_o    (cmd_reset),
        .cmd_arm_o      (cmd_arm),
        .id_req_o       (id_req),
        .cfg_drop_o     (cfg_drop),
        .trig_mask_o    (trig_mask),
        .trig_val_o     (trig_val),
        .trig_cfg_o     (trig_cfg),
        .divider_o      (divider),
        .read_cnt_o     (read_cnt),
        .delay_cnt_o    (delay_cnt),
        .flags_o        (flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Command-level model: a long command is an opcode plus four collected bytes; its write
    // lands one edge after the fourth byte, using busy at that edge.
    bit          m_long = 0;
    logic [7:0]  m_op = 8'h00;
    logic [7:0]  m_bytes [4];
    int          m_n = 0;
    int          m_idle = 0;
    bit          m_pend = 0;
    logic [7:0]  p_op = 8'h00;
    logic [31:0] p_pay = 32'h0;
    logic        e_reset = 0, e_arm = 0, e_id = 0, e_drop = 0;
    logic [31:0] e_mask = 0, e_val = 0, e_cfg = 0;
    logic [23:0] e_div = 0;
    logic [15:0] e_read = 0, e_delay = 0;
    logic [7:0]  e_flags = 0;

    always @(posedge clk) begin
        e_reset = 0; e_arm = 0; e_id = 0; e_drop = 0;
        if (!rst_n) begin
            m_long = 0; m_n = 0; m_idle = 0; m_pend = 0;
            e_mask = 0; e_val = 0; e_cfg = 0; e_div = 0;
            e_read = 0; e_delay = 0; e_flags = 0;
        end else begin
            if (m_pend) begin
                m_pend = 0;
                if (p_op inside {8'hC0, 8'hC1, 8'hC2, 8'h80, 8'h81, 8'h82}) begin
                    if (busy) e_drop = 1;
                    else case (p_op)
                        8'hC0: e_mask = p_pay;
                        8'hC1: e_val = p_pay;
                        8'hC2: e_cfg = p_pay;
                        8'h80: e_div = p_pay[23:0];
                        8'h81: begin e_read = p_pay[15:0]; e_delay = p_pay[31:16]; end
                        default: e_flags = p_pay[7:0];
                    endcase
                end
            end
            if (rx_valid) begin
                if (m_long) begin
                    m_bytes[m_n] = rx_data;
                    m_n++;
                    m_idle = 0;
                    if (m_n == 4) begin
                        m_long = 0;
                        m_pend = 1;
                        p_op = m_op;
                        p_pay = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    end
                end else if (rx_data[7]) begin
                    m_long = 1; m_op = rx_data; m_n = 0; m_idle = 0;
                end else begin
                    e_reset = (rx_data == 8'h00);
                    e_arm   = (rx_data == 8'h01) && !busy;
                    e_id    = (rx_data == 8'h02);
                end
            end else if (m_long) begin
`ifdef LOGIP_CMD_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) m_long = 0;
`endif
            end
        end
    end

    bit check_en = 0;
    int n_reset = 0, n_arm = 0, n_id = 0, n_drop = 0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmd_reset", cmd_reset, e_reset);
            chk("cmd_arm", cmd_arm, e_arm);
            chk("id_req", id_req, e_id);
            chk("cfg_drop", cfg_drop, e_drop);
            chk("trig_mask", trig_mask, e_mask);
            chk("trig_val", trig_val, e_val);
            chk("trig_cfg", trig_cfg, e_cfg);
            chk("divider", divider, e_div);
            chk("read_cnt", read_cnt, e_read);
            chk("delay_cnt", delay_cnt, e_delay);
            chk("flags", flags, e_flags);
        end
        if (cmd_reset === 1'b1) n_reset++;
        if (cmd_arm === 1'b1) n_arm++;
        if (id_req === 1'b1) n_id++;
        if (cfg_drop === 1'b1) n_drop++;
    end

    // Every call starts and ends 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_long(input logic [7:0] op, input logic [31:0] pay, input int gap);
        send(op, gap);
        for (int i = 0; i < 4; i++) send(pay[8*i +: 8], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        @(posedge clk); #1;
        check_en = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("lit_reset_mask", trig_mask, 32'h0);
        chk("lit_reset_div", divider, 24'h0);
        chk("lit_reset_pulses", {cmd_reset, cmd_arm, id_req, cfg_drop}, 4'b0);

        n_reset = 0; n_id = 0;
        send(8'h02, 1);
        send(8'h00, 1);
        idle(2);
        chk("lit_id_count", n_id, 1);
        chk("lit_reset_count", n_reset, 1);

        n_arm = 0;
        busy = 1'b0; send(8'h01, 1);
        busy = 1'b1; send(8'h01, 1);
        busy = 1'b0; idle(2);
        chk("lit_arm_count", n_arm, 1);

        send_long(8'hC0, 32'h12345678, 0);
        idle(2);
        chk("lit_trig_mask", trig_mask, 32'h12345678);
        chk("lit_model_mask", e_mask, 32'h12345678);

        send_long(8'h81, 32'h00200010, 1);
        idle(2);
        chk("lit_read_cnt", read_cnt, 16'h0010);
        chk("lit_delay_cnt", delay_cnt, 16'h0020);

        send_long(8'h80, 32'hAAFFFFFF, 2);
        idle(2);
        chk("lit_divider", divider, 24'hFFFFFF);

        n_drop = 0;
        busy = 1'b1;
        send_long(8'hC1, 32'h00000001, 0);
        idle(3);
        busy = 1'b0;
        chk("lit_val_kept", trig_val, 32'h0);
        chk("lit_drop_count", n_drop, 1);
        send_long(8'hC1, 32'h00000001, 0);
        idle(2);
        chk("lit_val_set", trig_val, 32'h00000001);

        n_reset = 0;
        send(8'hC0, 1);
        send(8'hAA, 1);
        for (int i = 0; i < 5; i++) send(8'h00, 1);
        idle(2);
        chk("lit_resync_mask", trig_mask, 32'h000000AA);
        chk("lit_resync_resets", n_reset, 2);

        n_drop = 0;
        busy = 1'b1;
        send_long(8'hC5, 32'h44332211, 1);
        idle(2);
        busy = 1'b0;
        chk("lit_unknown_drop", n_drop, 0);
        chk("lit_unknown_mask", trig_mask, 32'h000000AA);

        n_id = 0;
        send(8'hC2, 1);
        send(8'h11, 1);
        send(8'h22, 1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send(8'h02, 1);
        send(8'h33, 1);
        send(8'h44, 1);
        idle(2);
        chk("lit_midreset_cfg", trig_cfg, 32'h0);
        chk("lit_midreset_id", n_id, 1);

        n_id = 0;
        send(8'h82, 1);
        send(8'h01, 1);
        idle(20);
        send(8'h02, 1);
`ifdef LOGIP_CMD_TIMEOUT_EN
        idle(2);
        chk("lit_timeout_flags", flags, 8'h00);
        chk("lit_timeout_id", n_id, 1);
`else
        send(8'h00, 1);
        send(8'h00, 1);
        idle(2);
        chk("lit_notimeout_flags", flags, 8'h01);
        chk("lit_notimeout_id", n_id, 0);
`endif

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
